// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder
//
// Receive-side decoder for 640x480-style VGA sync timing. It watches only
// the hsync/vsync pair, advances once per pixel strobe, and recovers the
// pixel coordinates, the active-video flag and line/frame markers. It also
// checks the incoming timing against the nominal mode, reports lock, and
// flags violations.
//
// Ports:
//   i_clk          system clock
//   i_rst_n        synchronous active-low reset
//   i_pix_stb      pixel strobe, one i_clk pulse per pixel
//   i_hs, i_vs     horizontal / vertical sync inputs (level SYNC_POL = asserted)
//   o_x, o_y       active pixel coordinates, 0 outside active video or when unlocked
//   o_active       current pixel lies in the active area (only while locked)
//   o_line_start   one-cycle pulse at hsync assertion (suppressed while searching)
//   o_frame_start  one-cycle pulse at pixel (0,0) while locked
//   o_locked       timing verified over a full frame
//   o_err          sticky violation flag, cleared by reset only
//   o_err_cnt      saturating violation count
//
// Optional feature: define VGA_SYNC_DECODER_ERRCNT_EN to build the 8-bit
// saturating violation counter. Without it o_err_cnt stays 0.
//
// Pipeline: the syncs are sampled at strobe N, the edge is acted on at
// strobe N+1 (counters/state), and the output register shows it at N+2.

module vga_sync_decoder #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 0
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_pix_stb,
  input  logic       i_hs,
  input  logic       i_vs,
  output logic [9:0] o_x,
  output logic [8:0] o_y,
  output logic       o_active,
  output logic       o_line_start,
  output logic       o_frame_start,
  output logic       o_locked,
  output logic       o_err,
  output logic [7:0] o_err_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST      = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_SYNC_LAST = 10'(H_SYNC - 1);
  localparam logic [9:0] H_START     = 10'(H_SYNC + H_BP);
  localparam logic [9:0] H_END       = 10'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [9:0] V_LAST      = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_START     = 10'(V_SYNC + V_BP);
  localparam logic [9:0] V_END       = 10'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [9:0] CNT_MAX     = 10'h3FF;
  localparam logic       SYNC_LVL    = (SYNC_POL != 0);

  typedef enum logic [1:0] {
    SEARCH,
    ALIGN,
    MEASURE,
    LOCKED
  } state_t;

  state_t     state;
  state_t     state_nx;

  logic       hs_s;
  logic       hs_d;
  logic       vs_s;
  logic       vs_d;
  logic [9:0] hcnt;
  logic [9:0] vcnt;
  logic       vs_pend;
  logic       line_evt;
  logic       err_sticky;
  logic [7:0] err_cnt;

  logic       hs_rise;
  logic       hs_fall;
  logic       vs_rise;
  logic       consume;
  logic       checking;
  logic [1:0] viol_cnt;
  logic       violation;

  logic       h_act;
  logic       v_act;
  logic       pix_act;
  logic [9:0] x_off;
  logic [8:0] y_off;

  // Edge detection runs on the sampled pair so both edges compare against
  // the previous strobe's sample, never against the raw asynchronous input.
  assign hs_rise = (hs_s == SYNC_LVL) && (hs_d != SYNC_LVL);
  assign hs_fall = (hs_s != SYNC_LVL) && (hs_d == SYNC_LVL);
  assign vs_rise = (vs_s == SYNC_LVL) && (vs_d != SYNC_LVL);

  // A same-strobe vsync counts as already pending, so the hsync consumes it.
  assign consume = hs_rise && (vs_pend || vs_rise);

  assign checking = (state == MEASURE) || (state == LOCKED);

  // Timing checks and FSM next-state. The line/width checks fire on opposite
  // hsync edges, so at most two checks can fail on the same strobe.
  always_comb begin
    viol_cnt = 2'd0;
    state_nx = state;

    if (checking) begin
      viol_cnt = {1'b0, hs_rise && (hcnt != H_LAST)}
               + {1'b0, hs_fall && (hcnt != H_SYNC_LAST)}
               + {1'b0, consume && (vcnt != V_LAST)};
    end

    if (i_pix_stb) begin
      case (state)
        SEARCH: begin
          if (vs_rise) begin
            state_nx = hs_rise ? MEASURE : ALIGN;
          end
        end
        ALIGN: begin
          if (consume) begin
            state_nx = MEASURE;
          end
        end
        MEASURE: begin
          if (viol_cnt != 2'd0) begin
            state_nx = SEARCH;
          end else if (consume) begin
            state_nx = LOCKED;
          end
        end
        LOCKED: begin
          if (viol_cnt != 2'd0) begin
            state_nx = SEARCH;
          end
        end
        default: state_nx = SEARCH;
      endcase
    end
  end

  assign violation = (viol_cnt != 2'd0);

  // Sync sampling, position counters, vsync bookkeeping and the state
  // register. Everything holds between strobes.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      hs_s       <= ~SYNC_LVL;
      hs_d       <= ~SYNC_LVL;
      vs_s       <= ~SYNC_LVL;
      vs_d       <= ~SYNC_LVL;
      hcnt       <= 10'd0;
      vcnt       <= 10'd0;
      vs_pend    <= 1'b0;
      line_evt   <= 1'b0;
      err_sticky <= 1'b0;
      state      <= SEARCH;
    end else if (i_pix_stb) begin
      hs_s <= i_hs;
      hs_d <= hs_s;
      vs_s <= i_vs;
      vs_d <= vs_s;

      if (hs_rise) begin
        hcnt <= 10'd0;
      end else if (hcnt != CNT_MAX) begin
        hcnt <= hcnt + 10'd1;
      end

      if (consume) begin
        vcnt    <= 10'd0;
        vs_pend <= 1'b0;
      end else begin
        if (vs_rise) begin
          vs_pend <= 1'b1;
        end
        if (hs_rise && (vcnt != CNT_MAX)) begin
          vcnt <= vcnt + 10'd1;
        end
      end

      line_evt <= hs_rise;
      if (violation) begin
        err_sticky <= 1'b1;
      end
      state <= state_nx;
    end
  end

`ifdef VGA_SYNC_DECODER_ERRCNT_EN
  logic [8:0] err_sum;

  assign err_sum = {1'b0, err_cnt} + {7'd0, viol_cnt};

  // Violation counter saturates at 255 rather than wrapping.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      err_cnt <= 8'd0;
    end else if (i_pix_stb && violation) begin
      err_cnt <= err_sum[8] ? 8'hFF : err_sum[7:0];
    end
  end
`else
  assign err_cnt = 8'd0;
`endif

  assign h_act   = (hcnt >= H_START) && (hcnt < H_END);
  assign v_act   = (vcnt >= V_START) && (vcnt < V_END);
  assign pix_act = (state == LOCKED) && h_act && v_act;
  assign x_off   = hcnt - H_START;
  assign y_off   = vcnt[8:0] - V_START[8:0];

  // Output register. Pulses are cleared on the first non-strobe cycle so
  // they last exactly one i_clk cycle even at the slow strobe rate.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_x           <= 10'd0;
      o_y           <= 9'd0;
      o_active      <= 1'b0;
      o_line_start  <= 1'b0;
      o_frame_start <= 1'b0;
      o_locked      <= 1'b0;
      o_err         <= 1'b0;
      o_err_cnt     <= 8'd0;
    end else if (i_pix_stb) begin
      o_x           <= pix_act ? x_off : 10'd0;
      o_y           <= pix_act ? y_off : 9'd0;
      o_active      <= pix_act;
      o_line_start  <= line_evt && (state != SEARCH);
      o_frame_start <= pix_act && (hcnt == H_START) && (vcnt == V_START);
      o_locked      <= (state == LOCKED);
      o_err         <= err_sticky;
      o_err_cnt     <= err_cnt;
    end else begin
      o_line_start  <= 1'b0;
      o_frame_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb_vga_sync_decoder
//
// Directed bench for vga_sync_decoder using a shrunk video mode
// (15 pixels x 9 lines) so several frames fit in a short run. A small
// sync generator drives the DUT; every observation is tagged with the
// generator position applied two strobes earlier, which is what the
// outputs reflect.

module tb_vga_sync_decoder;

  localparam int H_ACTIVE = 8;
  localparam int H_FP     = 2;
  localparam int H_SYNC   = 3;
  localparam int H_BP     = 2;
  localparam int V_ACTIVE = 4;
  localparam int V_FP     = 1;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 2;
  localparam int H_TOT    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT    = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int FRAME    = H_TOT * V_TOT;

`ifdef VGA_SYNC_DECODER_ERRCNT_EN
  localparam int CNT_STEP = 1;
`else
  localparam int CNT_STEP = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pix_stb;
  logic       hs;
  logic       vs;
  logic [9:0] o_x;
  logic [8:0] o_y;
  logic       o_active;
  logic       o_line_start;
  logic       o_frame_start;
  logic       o_locked;
  logic       o_err;
  logic [7:0] o_err_cnt;

  always #5 clk = ~clk;

  vga_sync_decoder #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .SYNC_POL(0)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_pix_stb(pix_stb),
    .i_hs(hs),
    .i_vs(vs),
    .o_x(o_x),
    .o_y(o_y),
    .o_active(o_active),
    .o_line_start(o_line_start),
    .o_frame_start(o_frame_start),
    .o_locked(o_locked),
    .o_err(o_err),
    .o_err_cnt(o_err_cnt)
  );

  typedef struct {
    int gh;
    int gv;
    int x;
    int y;
    int act;
    int fs;
    int ls;
  } vec_t;

  vec_t vecs[8];

  int pass_cnt = 0;
  int total_cnt = 0;

  int gen_h, gen_v, line_len, hs_w, gen_vtot;
  bit all_short;
  int d0h, d0v, d1h, d1v, d2h, d2v;
  int ox, oy, oact, ols, ofs, olock, oerr, ocnt;
  int fs_seen, pulse_long;

  task automatic checkOutput(input string name, input int actual, input int expected);
    total_cnt++;
    if (actual == expected) begin
      pass_cnt++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic recordTimeout(input string name);
    total_cnt++;
    $display("[TB] FAIL %s: got no match within bound, expected match", name);
  endtask

  // One generator pixel per call. Starts and ends on a negedge; fast mode
  // keeps the strobe high so consecutive calls give back-to-back strobes.
  task automatic applyStimulus(input bit fast);
    hs = (gen_h < hs_w) ? 1'b0 : 1'b1;
    vs = (gen_v < V_SYNC) ? 1'b0 : 1'b1;
    pix_stb = 1'b1;
    d2h = d1h; d2v = d1v;
    d1h = d0h; d1v = d0v;
    d0h = gen_h; d0v = gen_v;
    gen_h++;
    if (gen_h >= line_len) begin
      gen_h = 0;
      line_len = all_short ? H_TOT - 1 : H_TOT;
      hs_w = H_SYNC;
      gen_v++;
      if (gen_v >= gen_vtot) gen_v = 0;
    end
    @(negedge clk);
    ox = int'(o_x); oy = int'(o_y); oact = int'(o_active);
    ols = int'(o_line_start); ofs = int'(o_frame_start);
    olock = int'(o_locked); oerr = int'(o_err); ocnt = int'(o_err_cnt);
    if (o_frame_start) fs_seen++;
    if (!fast) begin
      pix_stb = 1'b0;
      @(negedge clk);
      if (o_line_start || o_frame_start) pulse_long++;
      @(negedge clk);
      @(negedge clk);
    end
  endtask

  task automatic runUntilObs(input int h, input int v, input string name);
    for (int i = 0; i < 3 * FRAME; i++) begin
      applyStimulus(1'b0);
      if (d2h == h && d2v == v) return;
    end
    recordTimeout(name);
  endtask

  task automatic runUntilGen(input int h, input int v, input string name);
    for (int i = 0; i < 3 * FRAME; i++) begin
      if (gen_h == h && gen_v == v) return;
      applyStimulus(1'b0);
    end
    recordTimeout(name);
  endtask

  task automatic relock(input string name, input int exp_err);
    runUntilObs(0, 0, {name, "_b1"});
    checkOutput({name, "_measure_locked"}, olock, 0);
    runUntilObs(0, 0, {name, "_b2"});
    checkOutput({name, "_locked"}, olock, 1);
    checkOutput({name, "_err"}, oerr, exp_err);
  endtask

  initial begin
    vecs[0] = '{gh: 0,  gv: 2, x: 0, y: 0, act: 0, fs: 0, ls: 1};
    vecs[1] = '{gh: 4,  gv: 4, x: 0, y: 0, act: 0, fs: 0, ls: 0};
    vecs[2] = '{gh: 5,  gv: 4, x: 0, y: 0, act: 1, fs: 1, ls: 0};
    vecs[3] = '{gh: 6,  gv: 4, x: 1, y: 0, act: 1, fs: 0, ls: 0};
    vecs[4] = '{gh: 7,  gv: 5, x: 2, y: 1, act: 1, fs: 0, ls: 0};
    vecs[5] = '{gh: 12, gv: 7, x: 7, y: 3, act: 1, fs: 0, ls: 0};
    vecs[6] = '{gh: 13, gv: 7, x: 0, y: 0, act: 0, fs: 0, ls: 0};
    vecs[7] = '{gh: 5,  gv: 8, x: 0, y: 0, act: 0, fs: 0, ls: 0};

    rst_n = 1'b0; pix_stb = 1'b0; hs = 1'b1; vs = 1'b1;
    gen_h = 0; gen_v = 0; line_len = H_TOT; hs_w = H_SYNC;
    gen_vtot = V_TOT; all_short = 1'b0;
    d0h = -1; d0v = -1; d1h = -1; d1v = -1; d2h = -1; d2v = -1;
    fs_seen = 0; pulse_long = 0;

    repeat (3) @(negedge clk);
    checkOutput("reset_x", int'(o_x), 0);
    checkOutput("reset_y", int'(o_y), 0);
    checkOutput("reset_active", int'(o_active), 0);
    checkOutput("reset_line_start", int'(o_line_start), 0);
    checkOutput("reset_frame_start", int'(o_frame_start), 0);
    checkOutput("reset_locked", int'(o_locked), 0);
    checkOutput("reset_err", int'(o_err), 0);
    checkOutput("reset_err_cnt", int'(o_err_cnt), 0);
    rst_n = 1'b1;

    // Acquisition: lock shows exactly at the first frame-boundary hsync.
    runUntilObs(H_TOT - 1, V_TOT - 1, "acq_end0");
    checkOutput("acq_locked_before", olock, 0);
    applyStimulus(1'b0);
    checkOutput("acq_locked_after", olock, 1);
    checkOutput("acq_err", oerr, 0);

    for (int i = 0; i < 8; i++) begin
      runUntilObs(vecs[i].gh, vecs[i].gv, $sformatf("vec%0d_wait", i));
      checkOutput($sformatf("vec%0d_x", i), ox, vecs[i].x);
      checkOutput($sformatf("vec%0d_y", i), oy, vecs[i].y);
      checkOutput($sformatf("vec%0d_active", i), oact, vecs[i].act);
      checkOutput($sformatf("vec%0d_frame_start", i), ofs, vecs[i].fs);
      checkOutput($sformatf("vec%0d_line_start", i), ols, vecs[i].ls);
      checkOutput($sformatf("vec%0d_locked", i), olock, 1);
    end

    // One frame_start per frame over two full frames.
    fs_seen = 0;
    pulse_long = 0;
    runUntilObs(0, 0, "fs_f2");
    runUntilObs(0, 0, "fs_f3");
    runUntilObs(0, 0, "fs_f4");
    checkOutput("frame_start_count", fs_seen, 2);
    checkOutput("pulse_one_cycle", pulse_long, 0);
    checkOutput("clean_err", oerr, 0);

    // Strobe gated off while the syncs wiggle: nothing may move.
    runUntilObs(7, 5, "gap_wait");
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      hs = 1'($urandom_range(0, 1));
      vs = 1'($urandom_range(0, 1));
    end
    checkOutput("gap_x", int'(o_x), 2);
    checkOutput("gap_y", int'(o_y), 1);
    checkOutput("gap_active", int'(o_active), 1);
    checkOutput("gap_locked", int'(o_locked), 1);
    applyStimulus(1'b0);
    checkOutput("gap_resume_x", ox, 3);
    checkOutput("gap_resume_err", oerr, 0);

    // Line 3 shortened by one pixel.
    runUntilGen(0, 3, "short_wait");
    line_len = H_TOT - 1;
    runUntilObs(H_TOT - 2, 3, "short_pre");
    checkOutput("short_pre_locked", olock, 1);
    checkOutput("short_pre_err", oerr, 0);
    applyStimulus(1'b0);
    checkOutput("short_err", oerr, 1);
    checkOutput("short_locked", olock, 0);
    checkOutput("short_err_cnt", ocnt, CNT_STEP);
    relock("short_relock", 1);

    // One hsync pulse a pixel too narrow.
    runUntilGen(0, 2, "width_wait");
    hs_w = H_SYNC - 1;
    runUntilObs(1, 2, "width_pre");
    checkOutput("width_pre_locked", olock, 1);
    applyStimulus(1'b0);
    checkOutput("width_locked", olock, 0);
    checkOutput("width_err_cnt", ocnt, 2 * CNT_STEP);
    relock("width_relock", 1);

    // Reset mid-frame while locked.
    runUntilObs(8, 5, "rst_wait");
    checkOutput("rst_pre_x", ox, 3);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("rst_x", int'(o_x), 0);
    checkOutput("rst_y", int'(o_y), 0);
    checkOutput("rst_active", int'(o_active), 0);
    checkOutput("rst_locked", int'(o_locked), 0);
    checkOutput("rst_err", int'(o_err), 0);
    checkOutput("rst_err_cnt", int'(o_err_cnt), 0);
    rst_n = 1'b1;
    relock("rst_relock", 0);
    checkOutput("rst_relock_cnt", ocnt, 0);

`ifdef VGA_SYNC_DECODER_ERRCNT_EN
    // 300 short 3-line frames, each costing exactly one violation.
    runUntilGen(0, 0, "sat_wait");
    all_short = 1'b1;
    line_len = H_TOT - 1;
    gen_vtot = 3;
    for (int i = 0; i < 300 * 3 * (H_TOT - 1); i++) begin
      applyStimulus(1'b1);
    end
    pix_stb = 1'b0;
    checkOutput("sat_err_cnt", ocnt, 255);
    checkOutput("sat_err", oerr, 1);
    checkOutput("sat_locked", olock, 0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
